i_mem_arbiter: RTL and testbench

- Arbitrates single-port instruction SRAM (2048x32 macro, 1-cycle read latency) between two requesters: core instruction-fetch port (read-only) and program-loader/debug port (read/write).
- Sits between core fetch unit / boot loader and the instruction-cache SRAM wrapper; drives macro ME/WE/ADR/D directly and returns Q.
- Loader has priority; a starvation guard guarantees core forward progress.

---
 rtl/i_mem_pkg.sv | 24 ++
 rtl/i_arb_starve_ctr.sv | 33 +++
 rtl/i_mem_arbiter.sv | 109 ++++++++++
 tb/tb_i_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_mem_pkg.sv
// rtl/i_mem_pkg.sv - shared types and sizing helpers for the instruction memory arbiter
package i_mem_pkg;

   localparam int I_SLICE_SIZE_DEF = 8192;
   localparam int STARVE_LIMIT_DEF = 4;

   // Who owns the SRAM read data returning in the following cycle
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_LD   = 2'd2
   } owner_e;

   // Word index width for a memory of the given size in bytes
   function automatic int word_idx_w(input int slice_bytes);
      return $clog2(slice_bytes) - 2;
   endfunction

   // Width of a counter able to hold 0..limit
   function automatic int starve_cnt_w(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/i_arb_starve_ctr.sv
// rtl/i_arb_starve_ctr.sv - consecutive-loss counter with force-grant flag for a low-priority requester
module i_arb_starve_ctr
   import i_mem_pkg::*;
#(
   parameter int  LIMIT = STARVE_LIMIT_DEF,
   localparam int CNT_W = starve_cnt_w(LIMIT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic gnt,
   input  logic lose,
   output logic force_gnt
);

   localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

   logic [CNT_W-1:0] cnt;

   assign force_gnt = (cnt == LIMIT_V);

   // Count cycles a pending request loses to the other side; any grant or dropped request restarts it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!req || gnt) begin
         cnt <= '0;
      end else if (lose && (cnt != LIMIT_V)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/i_mem_arbiter.sv
// rtl/i_mem_arbiter.sv - single-port I-SRAM arbiter, loader priority with core starvation guard; optional I_ARB_PERF_CNT_EN
module i_mem_arbiter
   import i_mem_pkg::*;
#(
   parameter int  I_SLICE_SIZE = I_SLICE_SIZE_DEF,
   parameter int  STARVE_LIMIT = STARVE_LIMIT_DEF,
   localparam int ADDR_W       = $clog2(I_SLICE_SIZE),
   localparam int WORD_W       = word_idx_w(I_SLICE_SIZE)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req,
   input  logic [31:0]       core_addr,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [31:0]       core_rdata,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [31:0]       ld_addr,
   input  logic [31:0]       ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   output logic [31:0]       ld_rdata,
   output logic              sram_me,
   output logic              sram_we,
   output logic [WORD_W-1:0] sram_adr,
   output logic [31:0]       sram_d,
   input  logic [31:0]       sram_q,
   output logic [31:0]       conflict_cnt
);

   logic        force_core;
   owner_e      owner;
   logic [31:0] sel_addr;
   logic        unused_addr_bits;

   i_arb_starve_ctr #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (core_req),
      .gnt      (core_gnt),
      .lose     (ld_gnt),
      .force_gnt(force_core)
   );

   // Loader wins contention unless the core has already lost STARVE_LIMIT cycles in a row
   always_comb begin
      core_gnt = core_req & (~ld_req | force_core);
      ld_gnt   = ld_req & ~core_gnt;
   end

   // Route the granted requester onto the macro pins; everything low when idle
   always_comb begin
      sel_addr = '0;
      if (core_gnt) begin
         sel_addr = core_addr;
      end else if (ld_gnt) begin
         sel_addr = ld_addr;
      end
      sram_me  = core_gnt | ld_gnt;
      sram_we  = ld_gnt & ld_we;
      sram_adr = sel_addr[ADDR_W-1:2];
      sram_d   = ld_gnt ? ld_wdata : '0;
   end

   // Byte offset and out-of-slice bits are dropped: word aligned, upper space aliases
   assign unused_addr_bits = ^{sel_addr[31:ADDR_W], sel_addr[1:0]};

   // Remember which requester the next-cycle read data belongs to; writes return nothing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner <= OWN_NONE;
      end else if (core_gnt) begin
         owner <= OWN_CORE;
      end else if (ld_gnt && !ld_we) begin
         owner <= OWN_LD;
      end else begin
         owner <= OWN_NONE;
      end
   end

   // Macro output is passed straight through to whichever side owns it, zero elsewhere
   always_comb begin
      core_rvalid = (owner == OWN_CORE);
      ld_rvalid   = (owner == OWN_LD);
      core_rdata  = core_rvalid ? sram_q : '0;
      ld_rdata    = ld_rvalid   ? sram_q : '0;
   end

`ifdef I_ARB_PERF_CNT_EN
   logic both_req;

   assign both_req = core_req & ld_req;

   // Count every cycle both requesters want the macro, wrapping naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict_cnt <= '0;
      end else if (both_req) begin
         conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`else
   assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_i_mem_arbiter.sv
// tb/tb_i_mem_arbiter.sv - self-checking bench for i_mem_arbiter with SRAM model and reference model
module tb_i_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_req;
   logic [31:0] core_addr;
   logic        core_gnt;
   logic        core_rvalid;
   logic [31:0] core_rdata;
   logic        ld_req;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_wdata;
   logic        ld_gnt;
   logic        ld_rvalid;
   logic [31:0] ld_rdata;
   logic        sram_me;
   logic        sram_we;
   logic [10:0] sram_adr;
   logic [31:0] sram_d;
   logic [31:0] sram_q;
   logic [31:0] conflict_cnt;

   always #5 clk = ~clk;

   i_mem_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_req    (core_req),
      .core_addr   (core_addr),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .ld_req      (ld_req),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_wdata    (ld_wdata),
      .ld_gnt      (ld_gnt),
      .ld_rvalid   (ld_rvalid),
      .ld_rdata    (ld_rdata),
      .sram_me     (sram_me),
      .sram_we     (sram_we),
      .sram_adr    (sram_adr),
      .sram_d      (sram_d),
      .sram_q      (sram_q),
      .conflict_cnt(conflict_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [31:0] init_word(input int i);
      return {16'hC0DE, 16'(i)};
   endfunction

   // SRAM macro model: 2048x32, one-cycle read latency
   logic [31:0] sram_mem [0:2047];
   initial begin
      for (int i = 0; i < 2048; i++) sram_mem[i] <= init_word(i);
   end
   always @(posedge clk) begin
      if (sram_me) begin
         if (sram_we) sram_mem[sram_adr] <= sram_d;
         else         sram_q <= sram_mem[sram_adr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model state: memory image, pending read, loss streak, conflict count
   logic [31:0] gold [0:2047];
   int          streak     = 0;
   int          pend       = 0;
   logic [31:0] pend_data  = '0;
   logic [31:0] conf_model = '0;
   bit          chk_en     = 0;
   logic        ecg, elg;
   logic [10:0] eadr;
   logic [31:0] exp_conf;

   initial begin
      for (int i = 0; i < 2048; i++) gold[i] = init_word(i);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         if (!rst_n) begin
            pend       = 0;
            streak     = 0;
            conf_model = '0;
         end
         ecg  = core_req && (!ld_req || streak >= LIMIT);
         elg  = ld_req && !ecg;
         eadr = ecg ? core_addr[12:2] : (elg ? ld_addr[12:2] : 11'd0);
         chk("core_gnt", 32'(core_gnt), 32'(ecg));
         chk("ld_gnt", 32'(ld_gnt), 32'(elg));
         chk("sram_me", 32'(sram_me), 32'(ecg || elg));
         chk("sram_we", 32'(sram_we), 32'(elg && ld_we));
         chk("sram_adr", 32'(sram_adr), 32'(eadr));
         if (elg && ld_we) chk("sram_d", sram_d, ld_wdata);
         else if (!ecg && !elg) chk("sram_d_idle", sram_d, 32'd0);
         chk("core_rvalid", 32'(core_rvalid), 32'(pend == 1));
         chk("core_rdata", core_rdata, (pend == 1) ? pend_data : 32'd0);
         chk("ld_rvalid", 32'(ld_rvalid), 32'(pend == 2));
         chk("ld_rdata", ld_rdata, (pend == 2) ? pend_data : 32'd0);
`ifdef I_ARB_PERF_CNT_EN
         exp_conf = conf_model;
`else
         exp_conf = 32'd0;
`endif
         chk("conflict_cnt", conflict_cnt, exp_conf);
         if (rst_n) begin
            pend_data = gold[eadr];
            if (elg && ld_we) gold[ld_addr[12:2]] = ld_wdata;
            pend = ecg ? 1 : ((elg && !ld_we) ? 2 : 0);
            if (ecg || !core_req) streak = 0;
            else if (elg) streak++;
            if (core_req && ld_req) conf_model = conf_model + 32'd1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      core_req = 1'b0;
      ld_req   = 1'b0;
      ld_we    = 1'b0;
   endtask

   string seq;

   initial begin
      rst_n     = 1'b0;
      idle();
      core_addr = '0;
      ld_addr   = '0;
      ld_wdata  = '0;
      chk_en    = 1;
      @(negedge clk);
      chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
      chk("rst_sram_me", 32'(sram_me), 32'd0);
      chk("rst_conflict", conflict_cnt, 32'd0);
      step();
      step();
      rst_n = 1'b1;

      // core-only read of word 4
      core_req  = 1'b1;
      core_addr = 32'h0000_0010;
      @(negedge clk);
      chk("t1_gnt", 32'(core_gnt), 32'd1);
      chk("t1_adr", 32'(sram_adr), 32'd4);
      step();
      idle();
      @(negedge clk);
      chk("t1_rvalid", 32'(core_rvalid), 32'd1);
      chk("t1_rdata", core_rdata, 32'hC0DE_0004);
      step();

      // loader write then core read of the same word
      ld_req   = 1'b1;
      ld_we    = 1'b1;
      ld_addr  = 32'h0000_0040;
      ld_wdata = 32'hDEAD_BEEF;
      step();
      idle();
      core_req  = 1'b1;
      core_addr = 32'h0000_0040;
      @(negedge clk);
      chk("t2_no_ld_rvalid", 32'(ld_rvalid), 32'd0);
      step();
      idle();
      @(negedge clk);
      chk("t2_rdata", core_rdata, 32'hDEAD_BEEF);
      step();

      // loader read-back
      ld_req  = 1'b1;
      ld_we   = 1'b0;
      ld_addr = 32'h0000_0040;
      step();
      idle();
      @(negedge clk);
      chk("t3_ld_rdata", ld_rdata, 32'hDEAD_BEEF);
      chk("t3_core_rdata_zero", core_rdata, 32'd0);
      step();

      // back-to-back core reads, one per cycle
      for (int i = 0; i < 6; i++) begin
         core_req  = 1'b1;
         core_addr = 32'h0000_0100 + 32'(i * 4);
         step();
      end
      idle();
      step();

      // aliasing and byte-offset stripping
      core_req  = 1'b1;
      core_addr = 32'h0000_2043;
      @(negedge clk);
      chk("alias_adr", 32'(sram_adr), 32'h010);
      step();
      idle();
      @(negedge clk);
      chk("alias_rdata", core_rdata, 32'hDEAD_BEEF);
      step();

      // contention with starvation guard
      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      core_req  = 1'b1;
      core_addr = 32'h0000_0200;
      ld_req    = 1'b1;
      ld_we     = 1'b0;
      ld_addr   = 32'h0000_0300;
      seq       = "";
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (core_gnt)    seq = {seq, "C"};
         else if (ld_gnt) seq = {seq, "L"};
         else             seq = {seq, "-"};
         step();
      end
      idle();
      n_tests++;
      if (seq != "LLLLCLLLLC") begin
         n_fail++;
         $display("FAIL grant_seq: got %s expected LLLLCLLLLC", seq);
      end
      step();

      // reset while a core read is in flight
      core_req  = 1'b1;
      core_addr = 32'h0000_0008;
      @(negedge clk);
      chk("rmr_gnt", 32'(core_gnt), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      chk("rmr_rvalid_in_rst", 32'(core_rvalid), 32'd0);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rmr_rvalid_after", 32'(core_rvalid), 32'd0);
         step();
      end

      // conflict counter over 7 contended cycles
      rst_n = 1'b0;
      step();
      rst_n     = 1'b1;
      core_req  = 1'b1;
      ld_req    = 1'b1;
      ld_we     = 1'b0;
      core_addr = 32'h0000_0000;
      ld_addr   = 32'h0000_0004;
      repeat (7) step();
      idle();
      @(negedge clk);
`ifdef I_ARB_PERF_CNT_EN
      chk("perf_cnt", conflict_cnt, 32'd7);
`else
      chk("perf_cnt", conflict_cnt, 32'd0);
`endif
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
